accel_smoother: RTL
===================

Name: accel_smoother

Overview:
- Moving-average filter between the accelerometer sample interface and the video/sprite stage.
- Accepts raw signed 10-bit X/Y tilt samples, one per `sample_valid` strobe.
- Produces `smooth_outx` / `smooth_outy`, which the pixel-colour stage consumes directly.
- Filter is a 2^LOG2_DEPTH-tap boxcar, implemented as a circular buffer plus a running sum per axis.

Parameters:
- WIDTH, 10, sample and output width (two's complement).
- LOG2_DEPTH, 3, log2 of averaging window (default 8 taps).
- DEADZONE, 4, magnitude at or below which output is forced to 0 (used only with the optional feature).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- sample_valid  in  1  one-cycle strobe; accel_x/accel_y valid this cycle.
- accel_x  in  WIDTH  raw X sample, signed.
- accel_y  in  WIDTH  raw Y sample, signed.
- smooth_outx  out  WIDTH  averaged X, signed, registered.
- smooth_outy  out  WIDTH  averaged Y, signed, registered.
- smooth_valid  out  1  one-cycle strobe: new smooth_outx/y this cycle.
- primed  out  1  high once the window has been filled since reset.
- fill_count  out  LOG2_DEPTH+1  samples accepted since reset, saturating at 2^LOG2_DEPTH.

Behaviour:
- Reset (sync, active-high):
  - All buffer entries, both running sums and wr_ptr go to 0.
  - smooth_outx = smooth_outy = 0; smooth_valid = 0; primed = 0; fill_count = 0; state = FILL.
  - Reset has priority over a coincident sample_valid; that sample is dropped.
- Per accepted sample (sample_valid = 1, reset = 0), per axis:
  - sum_next = sum + sample − buf[wr_ptr].
  - buf[wr_ptr] ← sample.
  - wr_ptr ← wr_ptr + 1, wrapping modulo 2^LOG2_DEPTH.
- Arithmetic:
  - Sums are signed, WIDTH+LOG2_DEPTH bits wide; overflow is impossible.
  - Average = sum_next arithmetic-shifted right by LOG2_DEPTH, i.e. floor toward −inf (−1/8 → −1).
  - The result always fits in WIDTH bits; no saturation logic is needed.
- State machine:
  - FILL:
    - Each sample increments fill_count.
    - smooth_valid stays 0 and the outputs hold 0.
    - The sample that brings fill_count to 2^LOG2_DEPTH moves the state to RUN and sets primed.
    - That same sample produces the first smooth_valid.
  - RUN:
    - Every accepted sample produces smooth_valid exactly 1 cycle later (registered).
    - Outputs update in the same cycle smooth_valid is high and hold until the next strobe.
    - fill_count stays at 2^LOG2_DEPTH.
    - RUN exits only via reset.
- Latency: output reflects the sample accepted on the previous edge (1 cycle).
- Throughput: sample_valid may be high on consecutive cycles; every sample is processed and each produces its own smooth_valid pulse.
- With sample_valid low, nothing changes except smooth_valid, which returns to 0.
- Reset mid-FILL or mid-RUN discards the window and the next sample starts a fresh FILL.

Optional Feature:
- Macro: ACCEL_DEADZONE_EN.
- Defined:
  - After averaging, any axis result with magnitude ≤ DEADZONE (−DEADZONE..+DEADZONE) is output as 0.
  - Other values pass unchanged.
  - Each axis is evaluated independently.
  - The running sums and buffer are unaffected.
- Undefined: the averaged value is output directly; the DEADZONE parameter is ignored.

Test Plan:
- Fill: reset, then 8 strobes with x=100, y=−100 (10'b1110011100):
  - no smooth_valid for strobes 1–7; fill_count = 1..7;
  - after strobe 8: smooth_valid = 1 one cycle later, smooth_outx = 100, smooth_outy = −100, primed = 1.
- Sliding window: primed at all-zero samples, then one strobe x=80, y=−1:
  - smooth_outx = 10, smooth_outy = −1 (10'h3FF, floor).
  - Seven further zero strobes keep x = 10; the 8th zero strobe returns x to 0.
- Extremes and back-to-back: 8 consecutive-cycle strobes x=−512, y=511:
  - 8 consecutive smooth_valid pulses, each one cycle after its strobe;
  - final output −512 / 511, no overflow.
- Reset mid-operation:
  - After 5 strobes of x=200, assert reset coincident with a 6th strobe: that sample is dropped, fill_count = 0, primed = 0.
  - Then 8 strobes of x=−150 (10'b1101101010) → smooth_outx = −150.
- Deadzone (ACCEL_DEADZONE_EN defined), from a primed all-zero window:
  - one strobe x=32 → 0 (avg 4);
  - next strobe x=8 → 5 passes;
  - y=−40 after zeros → −5 passes, y=−32 → 0.
  - Without the macro, x=32 → 4.
- Idle hold: after a valid output, 20 cycles with sample_valid low → outputs unchanged, smooth_valid = 0 throughout.

Source files
------------

// File: rtl/accel_smoother.sv
// Purpose: 2^LOG2_DEPTH-tap boxcar average of signed X/Y tilt samples (circular buffer + running sum per axis).
// Latency: smooth_outx/y and smooth_valid are registered, one cycle after the accepted sample.
// Backpressure: none; a sample may arrive every cycle and each one is absorbed and (once primed) produces its own pulse.
// Optional: define ACCEL_DEADZONE_EN to force averaged results with |avg| <= DEADZONE to zero.
module accel_smoother #(
  parameter int WIDTH      = 10,
  parameter int LOG2_DEPTH = 3,
  parameter int DEADZONE   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] accel_x,
  input  logic signed [WIDTH-1:0] accel_y,
  output logic signed [WIDTH-1:0] smooth_outx,
  output logic signed [WIDTH-1:0] smooth_outy,
  output logic                    smooth_valid,
  output logic                    primed,
  output logic [LOG2_DEPTH:0]     fill_count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  // Sum of DEPTH WIDTH-bit samples needs exactly LOG2_DEPTH extra bits.
  localparam int SW    = WIDTH + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0]   FILL_ONE  = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH:0]   FILL_LAST = (LOG2_DEPTH+1)'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);

`ifdef ACCEL_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  localparam logic signed [WIDTH-1:0] DZ_POS = WIDTH'(DEADZONE);
  localparam logic signed [WIDTH-1:0] DZ_NEG = -DZ_POS;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] buf_x_q [DEPTH];
  logic signed [WIDTH-1:0] buf_x_d [DEPTH];
  logic signed [WIDTH-1:0] buf_y_q [DEPTH];
  logic signed [WIDTH-1:0] buf_y_d [DEPTH];
  logic signed [SW-1:0]    sum_x_q, sum_x_d;
  logic signed [SW-1:0]    sum_y_q, sum_y_d;
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]     fill_count_q, fill_count_d;
  logic                    primed_q, primed_d;
  logic                    smooth_valid_q, smooth_valid_d;
  logic signed [WIDTH-1:0] smooth_outx_q, smooth_outx_d;
  logic signed [WIDTH-1:0] smooth_outy_q, smooth_outy_d;

  logic signed [SW-1:0]    sum_x_nxt, sum_y_nxt;
  logic signed [WIDTH-1:0] avg_x, avg_y;

  // Sign-extend a sample to running-sum width.
  function automatic logic signed [SW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{LOG2_DEPTH{v[WIDTH-1]}}, v};
  endfunction

  // Optional dead-zone shaping of one averaged axis; sums and buffer never see it.
  function automatic logic signed [WIDTH-1:0] shape(input logic signed [WIDTH-1:0] v);
    if (DZ_EN && (v >= DZ_NEG) && (v <= DZ_POS)) begin
      return '0;
    end
    return v;
  endfunction

  // Running-sum update and average for the sample currently presented.
  always_comb begin
    sum_x_nxt = sum_x_q + sext(accel_x) - sext(buf_x_q[wr_ptr_q]);
    sum_y_nxt = sum_y_q + sext(accel_y) - sext(buf_y_q[wr_ptr_q]);
    // Taking the upper WIDTH bits is the arithmetic shift right by LOG2_DEPTH
    // (floor toward -inf); the result always fits, so no saturation.
    avg_x     = sum_x_nxt[SW-1:LOG2_DEPTH];
    avg_y     = sum_y_nxt[SW-1:LOG2_DEPTH];
  end

  // Next-state, window update and output strobe (FILL until the window is full, then RUN).
  always_comb begin
    state_d        = state_q;
    buf_x_d        = buf_x_q;
    buf_y_d        = buf_y_q;
    sum_x_d        = sum_x_q;
    sum_y_d        = sum_y_q;
    wr_ptr_d       = wr_ptr_q;
    fill_count_d   = fill_count_q;
    primed_d       = primed_q;
    smooth_valid_d = 1'b0;
    smooth_outx_d  = smooth_outx_q;
    smooth_outy_d  = smooth_outy_q;

    if (sample_valid) begin
      buf_x_d[wr_ptr_q] = accel_x;
      buf_y_d[wr_ptr_q] = accel_y;
      sum_x_d           = sum_x_nxt;
      sum_y_d           = sum_y_nxt;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;

      unique case (state_q)
        ST_FILL: begin
          fill_count_d = fill_count_q + FILL_ONE;
          // The sample that completes the window also yields the first output.
          if (fill_count_q == FILL_LAST) begin
            state_d        = ST_RUN;
            primed_d       = 1'b1;
            smooth_valid_d = 1'b1;
            smooth_outx_d  = shape(avg_x);
            smooth_outy_d  = shape(avg_y);
          end
        end
        ST_RUN: begin
          smooth_valid_d = 1'b1;
          smooth_outx_d  = shape(avg_x);
          smooth_outy_d  = shape(avg_y);
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  // State register; reset wins over a coincident sample, which is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_FILL;
      for (int i = 0; i < DEPTH; i++) begin
        buf_x_q[i] <= '0;
        buf_y_q[i] <= '0;
      end
      sum_x_q        <= '0;
      sum_y_q        <= '0;
      wr_ptr_q       <= '0;
      fill_count_q   <= '0;
      primed_q       <= 1'b0;
      smooth_valid_q <= 1'b0;
      smooth_outx_q  <= '0;
      smooth_outy_q  <= '0;
    end else begin
      state_q        <= state_d;
      buf_x_q        <= buf_x_d;
      buf_y_q        <= buf_y_d;
      sum_x_q        <= sum_x_d;
      sum_y_q        <= sum_y_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_count_q   <= fill_count_d;
      primed_q       <= primed_d;
      smooth_valid_q <= smooth_valid_d;
      smooth_outx_q  <= smooth_outx_d;
      smooth_outy_q  <= smooth_outy_d;
    end
  end

  assign smooth_outx  = smooth_outx_q;
  assign smooth_outy  = smooth_outy_q;
  assign smooth_valid = smooth_valid_q;
  assign primed       = primed_q;
  assign fill_count   = fill_count_q;

endmodule
